// File: rtl/pop_timers.sv
// Pump / pi-2 / free-precession / pi-2 / probe sequencer for POP clocks.
// Pulse lengths take edge-triggered, saturating adjustments between runs.
`timescale 1ns/1ps
module pop_timers #(
  parameter int WIDTH         = 16,
  parameter int PUMP_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 25,
  parameter int PIE_DEFAULT   = 10,
  parameter int FREE_DEFAULT  = 250,
  parameter int PROBE_CYCLES  = 250,
  parameter int SAMPLE_DELAY  = 50,
  parameter int SAMPLE_CYCLES = 5,
  parameter int PIE_STEP      = 1,
  parameter int PIE_MIN       = 1,
  parameter int PIE_MAX       = 1000,
  parameter int FREE_STEP     = 5,
  parameter int FREE_MIN      = 1,
  parameter int FREE_MAX      = 60000
) (
  input  logic clock_2_5M,
  input  logic load_defaults,
  input  logic pieovertwo_plus,
  input  logic pieovertwo_minus,
  input  logic freeprecess_plus,
  input  logic freeprecess_minus,
  output logic pump,
  output logic probe,
  output logic MW,
  output logic sample
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUMP, S_GAP1, S_MW1,
    S_FREE, S_MW2, S_GAP2, S_PROBE
  } state_t;

  localparam logic [WIDTH-1:0] PUMP_LAST =
    WIDTH'(PUMP_CYCLES - 1);
  localparam logic [WIDTH-1:0] GAP_LAST =
    WIDTH'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0] PROBE_LAST =
    WIDTH'(PROBE_CYCLES - 1);
  localparam logic [WIDTH-1:0] SMP_FIRST =
    WIDTH'(SAMPLE_DELAY);
  localparam logic [WIDTH-1:0] SMP_LAST =
    WIDTH'(SAMPLE_DELAY + SAMPLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_add(
    input logic [WIDTH-1:0] v,
    input int step,
    input int lim
  );
    logic [WIDTH:0] s;
    s = {1'b0, v} + (WIDTH+1)'(step);
    if (s > (WIDTH+1)'(lim)) return WIDTH'(lim);
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(
    input logic [WIDTH-1:0] v,
    input int step,
    input int lim
  );
    logic [WIDTH:0] floor_v;
    floor_v = (WIDTH+1)'(lim) + (WIDTH+1)'(step);
    if ({1'b0, v} < floor_v) return WIDTH'(lim);
    return v - WIDTH'(step);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pie_len_q, pie_len_d;
  logic [WIDTH-1:0] free_len_q, free_len_d;
  logic [WIDTH-1:0] pie_cur_q, pie_cur_d;
  logic [WIDTH-1:0] free_cur_q, free_cur_d;
  logic [3:0]       prev_q, prev_d;
  logic             pump_q, pump_d;
  logic             probe_q, probe_d;
  logic             mw_q, mw_d;
  logic             sample_q, sample_d;

  logic [3:0]       adj_in;
  logic [3:0]       rise;
  logic [WIDTH-1:0] last;
  state_t           nxt;

  assign adj_in = {pieovertwo_plus, pieovertwo_minus,
                   freeprecess_plus, freeprecess_minus};
  assign rise   = adj_in & ~prev_q;
  assign prev_d = adj_in;

  // Opposing edges in the same cycle cancel out.
  always_comb begin
    pie_len_d  = pie_len_q;
    free_len_d = free_len_q;
    unique case (1'b1)
      rise[3] & ~rise[2]:
        pie_len_d = sat_add(pie_len_q, PIE_STEP, PIE_MAX);
      rise[2] & ~rise[3]:
        pie_len_d = sat_sub(pie_len_q, PIE_STEP, PIE_MIN);
      default: ;
    endcase
    unique case (1'b1)
      rise[1] & ~rise[0]:
        free_len_d = sat_add(free_len_q, FREE_STEP, FREE_MAX);
      rise[0] & ~rise[1]:
        free_len_d = sat_sub(free_len_q, FREE_STEP, FREE_MIN);
      default: ;
    endcase
  end

  always_comb begin
    last = '0;
    nxt  = S_PUMP;
    unique case (state_q)
      S_IDLE:  begin last = '0;              nxt = S_PUMP;  end
      S_PUMP:  begin last = PUMP_LAST;       nxt = S_GAP1;  end
      S_GAP1:  begin last = GAP_LAST;        nxt = S_MW1;   end
      S_MW1:   begin last = pie_cur_q - ONE; nxt = S_FREE;  end
      S_FREE:  begin last = free_cur_q - ONE; nxt = S_MW2;  end
      S_MW2:   begin last = pie_cur_q - ONE; nxt = S_GAP2;  end
      S_GAP2:  begin last = GAP_LAST;        nxt = S_PROBE; end
      S_PROBE: begin last = PROBE_LAST;      nxt = S_PUMP;  end
      default: begin last = '0;              nxt = S_PUMP;  end
    endcase
  end

  // Working lengths are frozen at PUMP entry for the whole run.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + ONE;
    pie_cur_d  = pie_cur_q;
    free_cur_d = free_cur_q;
    if (cnt_q == last) begin
      state_d = nxt;
      cnt_d   = '0;
      if (nxt == S_PUMP) begin
        pie_cur_d  = pie_len_q;
        free_cur_d = free_len_q;
      end
    end
    pump_d   = (state_d == S_PUMP);
    mw_d     = (state_d == S_MW1) || (state_d == S_MW2);
    probe_d  = (state_d == S_PROBE);
    sample_d = probe_d && (cnt_d >= SMP_FIRST) &&
               (cnt_d <= SMP_LAST);
  end

  always_ff @(posedge clock_2_5M or negedge load_defaults) begin
    if (!load_defaults) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pie_len_q  <= WIDTH'(PIE_DEFAULT);
      free_len_q <= WIDTH'(FREE_DEFAULT);
      pie_cur_q  <= '0;
      free_cur_q <= '0;
      prev_q     <= '0;
      pump_q     <= 1'b0;
      probe_q    <= 1'b0;
      mw_q       <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pie_len_q  <= pie_len_d;
      free_len_q <= free_len_d;
      pie_cur_q  <= pie_cur_d;
      free_cur_q <= free_cur_d;
      prev_q     <= prev_d;
      pump_q     <= pump_d;
      probe_q    <= probe_d;
      mw_q       <= mw_d;
      sample_q   <= sample_d;
    end
  end

  assign pump   = pump_q;
  assign probe  = probe_q;
  assign MW     = mw_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_pop_timers.sv
// Self-checking bench for pop_timers: offset-based sequence model,
// directed timing scenarios and a randomized adjustment phase.
`timescale 1ns/1ps
module tb_pop_timers;

  logic       clk;
  logic       rst_n;
  logic [3:0] adj;
  logic       pump, probe, MW, sample;

  pop_timers dut (
    .clock_2_5M        (clk),
    .load_defaults     (rst_n),
    .pieovertwo_plus   (adj[3]),
    .pieovertwo_minus  (adj[2]),
    .freeprecess_plus  (adj[1]),
    .freeprecess_minus (adj[0]),
    .pump              (pump),
    .probe             (probe),
    .MW                (MW),
    .sample            (sample)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Model: position within the run decides every output.
  function automatic int seq_period(input int p, input int f);
    return 2 * 25 + 2 * p + f + 1000 + 250;
  endfunction

  function automatic logic [3:0] expect_out(
    input int o, input int p, input int f
  );
    int b1, b2, b3, b4, b5, b6;
    logic pu, mw, pr, sa;
    b1 = 1000;
    b2 = b1 + 25;
    b3 = b2 + p;
    b4 = b3 + f;
    b5 = b4 + p;
    b6 = b5 + 25;
    pu = (o < b1);
    mw = (o >= b2 && o < b3) || (o >= b4 && o < b5);
    pr = (o >= b6);
    sa = pr && (o - b6 >= 50) && (o - b6 < 55);
    return {pu, mw, pr, sa};
  endfunction

  int         m_pie, m_free, s_pie, s_free, off;
  bit         running;
  logic [3:0] m_prev, m_rise, exp_o;

  initial begin
    m_pie = 10; m_free = 250; s_pie = 10; s_free = 250;
    off = 0; running = 0; m_prev = 0; m_rise = 0; exp_o = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pie = 10; m_free = 250; running = 0;
        off = 0; m_prev = 0; exp_o = 0;
      end else begin
        m_rise = adj & ~m_prev;
        m_prev = adj;
        if (!running) begin
          running = 1; off = 0;
          s_pie = m_pie; s_free = m_free;
        end else begin
          off++;
          if (off == seq_period(s_pie, s_free)) begin
            off = 0;
            s_pie = m_pie; s_free = m_free;
          end
        end
        exp_o = expect_out(off, s_pie, s_free);
        if (m_rise[3] && !m_rise[2])
          m_pie = (m_pie + 1 > 1000) ? 1000 : m_pie + 1;
        if (m_rise[2] && !m_rise[3])
          m_pie = (m_pie - 1 < 1) ? 1 : m_pie - 1;
        if (m_rise[1] && !m_rise[0])
          m_free = (m_free + 5 > 60000) ? 60000 : m_free + 5;
        if (m_rise[0] && !m_rise[1])
          m_free = (m_free - 5 < 1) ? 1 : m_free - 5;
      end
    end
  end

  logic [3:0] hist[$];

  initial begin
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #100;
      got = {pump, MW, probe, sample};
      chk("cycle_outs", int'(got), int'(exp_o));
      if (rst_n) hist.push_back(got);
    end
  end

  function automatic int rise_idx(input int nth);
    int c;
    c = 0;
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i][3] && (i == 0 || !hist[i-1][3])) begin
        if (c == nth) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int num_rises();
    int c;
    c = 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i][3] && (i == 0 || !hist[i-1][3])) c++;
    return c;
  endfunction

  task automatic analyze(
    input string tag, input int nth,
    input int e_mw, input int e_free, input int e_per
  );
    int s, e, pl, prl, sl, a1, a2, a3, a4, ps, ss, t;
    logic [3:0] h;
    s = rise_idx(nth);
    e = rise_idx(nth + 1);
    if (s < 0 || e < 0) begin
      chk({tag, "_found"}, 0, 1);
      return;
    end
    pl = 0; prl = 0; sl = 0;
    a1 = -1; a2 = -1; a3 = -1; a4 = -1; ps = -1; ss = -1;
    for (int i = s; i < e; i++) begin
      t = i - s;
      h = hist[i];
      if (h[3]) pl++;
      if (h[1]) begin prl++; if (ps < 0) ps = t; end
      if (h[0]) begin sl++; if (ss < 0) ss = t; end
      if (h[2]) begin
        if (a1 < 0) a1 = t;
        else if (a2 >= 0 && a3 < 0) a3 = t;
      end else begin
        if (a1 >= 0 && a2 < 0) a2 = t;
        else if (a3 >= 0 && a4 < 0) a4 = t;
      end
    end
    chk({tag, "_pump"},   pl,      1000);
    chk({tag, "_gap1"},   a1 - pl, 25);
    chk({tag, "_mw1"},    a2 - a1, e_mw);
    chk({tag, "_free"},   a3 - a2, e_free);
    chk({tag, "_mw2"},    a4 - a3, e_mw);
    chk({tag, "_gap2"},   ps - a4, 25);
    chk({tag, "_probe"},  prl,     250);
    chk({tag, "_sdelay"}, ss - ps, 50);
    chk({tag, "_slen"},   sl,      5);
    chk({tag, "_period"}, e - s,   e_per);
  endtask

  task automatic pulses(input logic [3:0] m, input int n);
    repeat (n) begin
      @(negedge clk); adj = m;
      @(negedge clk); adj = 4'b0000;
    end
  endtask

  task automatic reset_cycle(input int n);
    @(negedge clk); rst_n = 1'b0;
    repeat (n) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    adj   = 4'b0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #100;
    chk("reset_outs", int'({pump, MW, probe, sample}), 0);

    // Default timing, then a deferred adjustment.
    @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
    @(posedge clk); #100;
    chk("first_edge_pump", int'(pump), 1);
    repeat (100) @(negedge clk);
    pulses(4'b0100, 4);
    pulses(4'b0010, 2);
    repeat (3100) @(negedge clk);
    analyze("dflt", 0, 10, 250, 1570);
    analyze("adj", 1, 6, 260, 1572);

    // Low saturation, held input, cancelling edges.
    reset_cycle(5);
    repeat (20) @(negedge clk);
    pulses(4'b0100, 12);
    @(negedge clk); adj = 4'b0010;
    repeat (100) @(negedge clk);
    adj = 4'b0000;
    repeat (1600) @(negedge clk);
    pulses(4'b1000, 1);
    pulses(4'b1101, 1);
    repeat (3050) @(negedge clk);
    analyze("sat_lo", 1, 1, 255, 1557);
    analyze("tie", 2, 2, 250, 1554);

    // High saturation of the pi/2 length.
    pulses(4'b1000, 1005);
    repeat (11000) @(negedge clk);
    analyze("sat_hi", num_rises() - 2, 1000, 250, 3550);

    // Abort inside MW1 and fall back to defaults.
    reset_cycle(5);
    repeat (50) @(negedge clk);
    pulses(4'b0100, 3);
    pulses(4'b0010, 2);
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #100;
      if (MW) begin found = 1; break; end
    end
    chk("mw1_seen", found, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", int'({pump, MW, probe, sample}), 0);
    repeat (10) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
    repeat (1600) @(negedge clk);
    analyze("restored", 0, 10, 250, 1570);

    // Random adjustment traffic with one mid-run reset.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i == 9000) rst_n = 1'b0;
      if (i == 9004) rst_n = 1'b1;
      for (int b = 0; b < 4; b++)
        adj[b] = ($urandom_range(0, 7) == 0);
    end
    adj = 4'b0000;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pop_timers.md
POP_TIMERS -- requirements
Module: pop_timers

Interface
REQ-001 Parameter WIDTH, default 16: width of all duration registers and counters.
REQ-002 Parameters with defaults, all durations in clock cycles:
- PUMP_CYCLES = 1000: pump pulse length.
- GAP_CYCLES = 25: dead time pump->MW and MW->probe.
- PIE_DEFAULT = 10: pi/2 MW pulse length.
- FREE_DEFAULT = 250: free-precession length.
- PROBE_CYCLES = 250: probe pulse length.
- SAMPLE_DELAY = 50: probe start to sample start.
- SAMPLE_CYCLES = 5: sample pulse length.
REQ-003 Parameters with defaults, adjustment controls:
- PIE_STEP = 1, PIE_MIN = 1, PIE_MAX = 1000: pi/2 adjustment step and limits.
- FREE_STEP = 5, FREE_MIN = 1, FREE_MAX = 60000: free-precession adjustment step and limits.
REQ-004 clock_2_5M, input, 1 bit: single 2.5 MHz system clock (400 ns tick); all logic on rising edge.
REQ-005 load_defaults, input, 1 bit: asynchronous active-low reset; restores default durations and restarts sequence.
REQ-006 Adjustment inputs, each input, 1 bit, synchronous:
- pieovertwo_plus: lengthen pi/2 pulse.
- pieovertwo_minus: shorten pi/2 pulse.
- freeprecess_plus: lengthen free precession.
- freeprecess_minus: shorten free precession.
REQ-007 Outputs, each output, 1 bit, registered:
- pump: pump laser gate.
- probe: probe laser gate.
- MW: microwave gate.
- sample: acquisition strobe.

Function
REQ-008 Sequencer SHALL be an FSM with states IDLE, PUMP, GAP1, MW1, FREE, MW2, GAP2, PROBE; after PROBE it SHALL return to PUMP and repeat indefinitely.
REQ-009 Each state SHALL last exactly its duration: PUMP_CYCLES, GAP_CYCLES, pie_len, free_len, pie_len, GAP_CYCLES, PROBE_CYCLES; period = 2*GAP + 2*pie_len + free_len + PUMP + PROBE (1570 cycles at defaults).
REQ-010 Output levels per state:
- pump = 1 only in PUMP.
- MW = 1 only in MW1/MW2.
- probe = 1 only in PROBE.
- sample = 1 during PROBE cycles SAMPLE_DELAY .. SAMPLE_DELAY+SAMPLE_CYCLES-1 (0-based).
- No two of pump/MW/probe ever high together.
REQ-011 pie_len and free_len SHALL be WIDTH-bit registers; the FSM SHALL latch them into working copies on entry to PUMP, so adjustments take effect at the next sequence, never mid-sequence.
REQ-012 Each adjustment input SHALL be rising-edge detected (registered previous value); each 0->1 transition applies exactly one step; a held-high input counts once.
REQ-013 Adjustments SHALL saturate:
- plus: new = min(value+STEP, MAX).
- minus: new = max(value-STEP, MIN).
- No wrap-around at either limit.
REQ-014 Simultaneous rising edges of plus and minus for the same quantity in one cycle SHALL leave it unchanged; pi/2 and free adjustments are independent and may occur in the same cycle.

Reset
REQ-015 While load_defaults = 0 (asynchronous):
- State = IDLE.
- pump/probe/MW/sample = 0.
- All counters = 0.
- pie_len = PIE_DEFAULT, free_len = FREE_DEFAULT.
- Edge-detect registers = 0.
REQ-016 First rising clock edge with load_defaults = 1 SHALL enter PUMP with pump = 1 at that edge.
REQ-017 Reset asserted mid-sequence SHALL abort the sequence immediately and discard all prior adjustments.

Verification
REQ-018 Release reset -> pump high 1000 cycles, low 25, MW high 10, low 250, MW high 10, low 25, probe high 250; sample high on probe cycles 50-54; pump re-asserts 1570 cycles after first assertion.
REQ-019 Four 1-cycle pieovertwo_minus pulses (separated by 1 low cycle), then two freeprecess_plus pulses -> next sequence MW pulses = 6 cycles each, free gap = 260, period = 1572; current sequence unaffected.
REQ-020 Twelve pieovertwo_minus pulses from default -> pie_len saturates at 1; freeprecess_plus held high 100 cycles -> free_len +5 only.
REQ-021 pieovertwo_plus and pieovertwo_minus rising together -> pie_len unchanged; freeprecess_minus in same cycle still decrements free_len.
REQ-022 Adjust values, then pulse load_defaults low 10 cycles mid-MW1 -> all outputs 0 immediately; after release, timing restored to 10/250 defaults, starting with pump.
